// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Control stage that sits in front of the interval counter. It turns the
//   start/stop/clear command levels into the counter's 8-bit state code. It
//   latches the requested terminal count and watches the value the counter
//   returns. When that value reaches the terminal count, it flags completion
//   and, if configured, restarts the counter automatically.
//
// Parameters
//   AUTO_RELOAD  1: completion restarts counting via a one-cycle RELOAD
//                0: completion parks the block in DONE
//   WRAP_W       width of the saturating completed-interval tally
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   start        command level, rising edge = start / resume
//   stop         command level, rising edge = pause
//   clear        command level, rising edge = abort and zero
//   interval_in  requested terminal count, sampled when a start is accepted
//   counter_in   current value returned by the counter
//   state        state code to the counter: 0 RESET, 1 RUN, 2 HALT (registered)
//   interval     latched terminal count to the counter (registered)
//   done         high while parked in DONE
//   done_pulse   one-cycle strobe per completed interval
//   wrap_count   completed intervals since clear/reset, saturating

module counter_ctrl #(
  parameter int AUTO_RELOAD = 0,
  parameter int WRAP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [31:0]       interval_in,
  input  logic [31:0]       counter_in,
  output logic [7:0]        state,
  output logic [31:0]       interval,
  output logic              done,
  output logic              done_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [7:0] CODE_RESET = 8'd0;
  localparam logic [7:0] CODE_RUN   = 8'd1;
  localparam logic [7:0] CODE_HALT  = 8'd2;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_CLEAR = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_HALT   = 3'd2,
    S_DONE   = 3'd3,
    S_RELOAD = 3'd4
  } fsm_t;

  fsm_t fsm, fsm_nxt;

  // ------------------------------------------------------------------
  // Command edge detection
  // ------------------------------------------------------------------
  logic [2:0] cmd_s1;
  logic [2:0] cmd_s2;
  logic [2:0] cmd_edge;

  // The detected edge is registered once more. This makes the FSM and its
  // registered outputs move together, two edges after a command level is
  // first sampled. The state code therefore changes on the same edge as the
  // FSM, so RELOAD's zero reaches the counter before RUN resumes comparing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_s1   <= '0;
      cmd_s2   <= '0;
      cmd_edge <= '0;
    end else begin
      cmd_s1   <= {clear, stop, start};
      cmd_s2   <= cmd_s1;
      cmd_edge <= cmd_s1 & ~cmd_s2;
    end
  end

  // Coincident edges resolve as clear > stop > start. A winning edge that
  // the current state ignores still suppresses the lower-priority ones.
  logic go_clear;
  logic go_stop;
  logic go_start;

  always_comb begin
    go_clear = cmd_edge[CMD_CLEAR];
    go_stop  = cmd_edge[CMD_STOP]  & ~cmd_edge[CMD_CLEAR];
    go_start = cmd_edge[CMD_START] & ~cmd_edge[CMD_STOP] & ~cmd_edge[CMD_CLEAR];
  end

  // ------------------------------------------------------------------
  // Next-state and next-output logic
  // ------------------------------------------------------------------
  logic [31:0]       interval_nxt;
  logic [WRAP_W-1:0] wrap_nxt;
  logic [WRAP_W-1:0] wrap_inc;
  logic              pulse_nxt;
  logic [7:0]        state_nxt;
  logic              start_ok;
  logic              reached;

  always_comb begin
    start_ok = go_start && (interval_in != '0);
    reached  = (counter_in >= interval);
    wrap_inc = (wrap_count == '1) ? wrap_count : wrap_count + WRAP_W'(1);
  end

  always_comb begin
    fsm_nxt      = fsm;
    interval_nxt = interval;
    wrap_nxt     = wrap_count;
    pulse_nxt    = 1'b0;

    case (fsm)
      S_IDLE: begin
        if (start_ok) begin
          interval_nxt = interval_in;
          fsm_nxt      = S_RUN;
        end
      end

      S_RUN: begin
        if (go_clear) begin
          fsm_nxt  = S_IDLE;
          wrap_nxt = '0;
        end else if (go_stop) begin
          fsm_nxt = S_HALT;
        end else if (reached) begin
          fsm_nxt   = (AUTO_RELOAD != 0) ? S_RELOAD : S_DONE;
          pulse_nxt = 1'b1;
          wrap_nxt  = wrap_inc;
        end
      end

      S_HALT: begin
        if (go_clear) begin
          fsm_nxt  = S_IDLE;
          wrap_nxt = '0;
        end else if (go_start) begin
          fsm_nxt = S_RUN;
        end
      end

      S_DONE: begin
        if (go_clear) begin
          fsm_nxt  = S_IDLE;
          wrap_nxt = '0;
        end else if (start_ok) begin
          interval_nxt = interval_in;
          fsm_nxt      = S_RELOAD;
        end
      end

      S_RELOAD: begin
        if (go_clear) begin
          fsm_nxt  = S_IDLE;
          wrap_nxt = '0;
        end else begin
          fsm_nxt = S_RUN;
        end
      end

      default: begin
        fsm_nxt      = S_IDLE;
        interval_nxt = '0;
        wrap_nxt     = '0;
      end
    endcase
  end

  always_comb begin
    state_nxt = CODE_RESET;
    case (fsm_nxt)
      S_RUN:            state_nxt = CODE_RUN;
      S_HALT, S_DONE:   state_nxt = CODE_HALT;
      default:          state_nxt = CODE_RESET;
    endcase
  end

  // ------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= S_IDLE;
      state      <= CODE_RESET;
      interval   <= '0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      fsm        <= fsm_nxt;
      state      <= state_nxt;
      interval   <= interval_nxt;
      done       <= (fsm_nxt == S_DONE);
      done_pulse <= pulse_nxt;
      wrap_count <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, clear;
  logic [31:0] interval_in;
  logic [31:0] cin0, cin1;

  logic [7:0]  state0, state1;
  logic [31:0] interval0, interval1;
  logic        done0, done1, pulse0, pulse1;
  logic [15:0] wrap0;
  logic [1:0]  wrap1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.AUTO_RELOAD(0), .WRAP_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .interval_in(interval_in), .counter_in(cin0),
    .state(state0), .interval(interval0), .done(done0),
    .done_pulse(pulse0), .wrap_count(wrap0)
  );

  counter_ctrl #(.AUTO_RELOAD(1), .WRAP_W(2)) dut_ar (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .interval_in(interval_in), .counter_in(cin1),
    .state(state1), .interval(interval1), .done(done1),
    .done_pulse(pulse1), .wrap_count(wrap1)
  );

  // Reference model: controller behaviour plus the external counter it drives.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_DONE = 3, M_RELOAD = 4;

  typedef struct {
    int          mode;
    logic [7:0]  st;
    logic [31:0] itv;
    logic        done;
    logic        pulse;
    int unsigned wrap;
    logic [2:0]  h0, h1, h2;   // command levels seen at the last three edges
    logic [31:0] cnt;          // external counter value
  } model_t;

  model_t m0, m1;

  function automatic model_t mstep(model_t m, int ar, int ww, logic r,
                                   logic [2:0] lv, logic [31:0] iin);
    model_t n;
    logic [2:0] cmd;
    logic clr, stp, sta;
    int unsigned wmax;
    n = m;
    wmax = (32'd1 << ww) - 1;
    // counter reacts to the code it saw before this edge
    if (m.st == 8'd0)      n.cnt = 0;
    else if (m.st == 8'd1) n.cnt = (m.cnt < m.itv) ? m.cnt + 1 : m.itv;
    n.pulse = 1'b0;
    if (r) begin
      n.mode = M_IDLE; n.st = 0; n.itv = 0; n.done = 0; n.wrap = 0;
      n.h0 = 0; n.h1 = 0; n.h2 = 0;
      return n;
    end
    // a level first sampled at edge N acts at edge N+2
    cmd = m.h1 & ~m.h2;
    n.h2 = m.h1; n.h1 = m.h0; n.h0 = lv;
    clr = cmd[2];
    stp = cmd[1] & ~cmd[2];
    sta = cmd[0] & ~cmd[1] & ~cmd[2];
    case (m.mode)
      M_IDLE:   if (sta && iin != 0) begin n.itv = iin; n.mode = M_RUN; end
      M_RUN: begin
        if (clr) begin n.mode = M_IDLE; n.wrap = 0; end
        else if (stp) n.mode = M_HALT;
        else if (m.cnt >= m.itv) begin
          n.mode = ar ? M_RELOAD : M_DONE;
          n.pulse = 1'b1;
          if (m.wrap < wmax) n.wrap = m.wrap + 1;
        end
      end
      M_HALT: begin
        if (clr) begin n.mode = M_IDLE; n.wrap = 0; end
        else if (sta) n.mode = M_RUN;
      end
      M_DONE: begin
        if (clr) begin n.mode = M_IDLE; n.wrap = 0; end
        else if (sta && iin != 0) begin n.itv = iin; n.mode = M_RELOAD; end
      end
      default: begin
        if (clr) begin n.mode = M_IDLE; n.wrap = 0; end
        else n.mode = M_RUN;
      end
    endcase
    n.st   = (n.mode == M_RUN) ? 8'd1 :
             (n.mode == M_HALT || n.mode == M_DONE) ? 8'd2 : 8'd0;
    n.done = (n.mode == M_DONE);
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= mstep(m0, 0, 16, rst, {clear, stop, start}, interval_in);
    m1 <= mstep(m1, 1, 2,  rst, {clear, stop, start}, interval_in);
  end

  assign cin0 = m0.cnt;
  assign cin1 = m1.cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({state0, interval0, done0, pulse0, wrap0} !== '0) begin
      tests_failed++;
      $display("FAIL reset_dut got st=%0d itv=%0d done=%0d pulse=%0d wrap=%0d want all 0",
               state0, interval0, done0, pulse0, wrap0);
    end
    tests_run++;
    if ({state1, interval1, done1, pulse1, wrap1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_dut_ar got st=%0d itv=%0d done=%0d wrap=%0d want all 0",
               state1, interval1, done1, wrap1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int np = 0;
    interval_in = 32'd5;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    tests_run++;
    if (state0 !== 8'd0) begin
      tests_failed++; $display("FAIL basic_latency1 got %0d want 0", state0);
    end
    tick();
    tests_run++;
    if (state0 !== 8'd1 || interval0 !== 32'd5) begin
      tests_failed++; $display("FAIL basic_run got st=%0d itv=%0d want st=1 itv=5", state0, interval0);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (pulse0) np++;
    end
    tests_run++;
    if (np != 1 || done0 !== 1'b1 || state0 !== 8'd2 || wrap0 !== 16'd1) begin
      tests_failed++;
      $display("FAIL basic_done got pulses=%0d done=%0d st=%0d wrap=%0d want 1/1/2/1",
               np, done0, state0, wrap0);
    end
  endtask

  task automatic test_halt();
    int np = 0;
    pulse_clear();
    repeat (4) tick();
    tests_run++;
    if (state0 !== 8'd0 || wrap0 !== 16'd0) begin
      tests_failed++; $display("FAIL halt_clear got st=%0d wrap=%0d want 0/0", state0, wrap0);
    end
    interval_in = 32'd100;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 200 && m0.cnt < 40; i++) tick();
    tests_run++;
    if (state0 !== 8'd1) begin
      tests_failed++; $display("FAIL halt_running got st=%0d want 1", state0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (2) tick();
    interval_in = 32'd7;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if ({state0, done0, pulse0} !== {8'd2, 2'b00}) begin
        tests_failed++;
        $display("FAIL halt_hold got st=%0d done=%0d pulse=%0d want 2/0/0", state0, done0, pulse0);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    tests_run++;
    if (state0 !== 8'd2) begin
      tests_failed++; $display("FAIL halt_resume_latency got st=%0d want 2", state0);
    end
    tick();
    tests_run++;
    if (state0 !== 8'd1 || interval0 !== 32'd100) begin
      tests_failed++; $display("FAIL halt_resume got st=%0d itv=%0d want 1/100", state0, interval0);
    end
    for (int i = 0; i < 200 && !done0; i++) begin
      tick();
      if (pulse0) np++;
    end
    tests_run++;
    if (np != 1 || state0 !== 8'd2 || wrap0 !== 16'd1 || m0.cnt !== 32'd100) begin
      tests_failed++;
      $display("FAIL halt_complete got pulses=%0d st=%0d wrap=%0d cnt=%0d want 1/2/1/100",
               np, state0, wrap0, m0.cnt);
    end
  endtask

  task automatic test_coincident();
    int np = 0;
    interval_in = 32'd50;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (state0 !== 8'd1 || wrap0 !== 16'd1) begin
      tests_failed++; $display("FAIL coinc_rerun got st=%0d wrap=%0d want 1/1", state0, wrap0);
    end
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    tick(); tick();
    tests_run++;
    if (state0 !== 8'd0 || wrap0 !== 16'd0 || done0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL coinc_clear got st=%0d wrap=%0d done=%0d want 0/0/0", state0, wrap0, done0);
    end
    interval_in = 32'd9;
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pulse0) np++;
    end
    start = 1'b0;
    tick();
    tests_run++;
    if (np != 1 || state0 !== 8'd2 || done0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_start got pulses=%0d st=%0d done=%0d want 1/2/1", np, state0, done0);
    end
  endtask

  task automatic test_zero_interval();
    pulse_clear();
    repeat (3) tick();
    interval_in = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (state0 !== 8'd0 || done0 !== 1'b0 || interval0 !== 32'd9) begin
      tests_failed++;
      $display("FAIL zero_itv got st=%0d done=%0d itv=%0d want 0/0/9", state0, done0, interval0);
    end
    interval_in = 32'd3;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    tests_run++;
    if (state0 !== 8'd1 || interval0 !== 32'd3) begin
      tests_failed++; $display("FAIL itv3_run got st=%0d itv=%0d want 1/3", state0, interval0);
    end
  endtask

  task automatic test_auto_reload();
    int np = 0;
    int last = -1;
    int sawdone = 0;
    pulse_clear();
    repeat (4) tick();
    interval_in = 32'd4;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done1) sawdone++;
      tests_run++;
      if ({state1, interval1, done1, pulse1, wrap1} !==
          {m1.st, m1.itv, m1.done, m1.pulse, 2'(m1.wrap)}) begin
        tests_failed++;
        $display("FAIL ar_model cyc=%0d got st=%0d itv=%0d done=%0d pulse=%0d wrap=%0d want %0d/%0d/%0d/%0d/%0d",
                 i, state1, interval1, done1, pulse1, wrap1,
                 m1.st, m1.itv, m1.done, m1.pulse, m1.wrap);
      end
      if (pulse1) begin
        np++;
        tests_run++;
        if (wrap1 !== 2'((np > 3) ? 3 : np)) begin
          tests_failed++;
          $display("FAIL ar_wrap got %0d want %0d", wrap1, (np > 3) ? 3 : np);
        end
        if (last >= 0) begin
          tests_run++;
          if (i - last != 6) begin
            tests_failed++; $display("FAIL ar_period got %0d want 6", i - last);
          end
        end
        last = i;
      end
    end
    tests_run++;
    if (np < 8 || wrap1 !== 2'd3 || sawdone != 0) begin
      tests_failed++;
      $display("FAIL ar_summary got pulses=%0d wrap=%0d done_cycles=%0d want >=8/3/0",
               np, wrap1, sawdone);
    end
  endtask

  task automatic test_rst_mid_run();
    pulse_clear();
    repeat (4) tick();
    interval_in = 32'd10;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30 && m0.cnt != 32'd2; i++) tick();
    tests_run++;
    if (state0 !== 8'd1 || cin0 !== 32'd2) begin
      tests_failed++; $display("FAIL rst_pre got st=%0d cnt=%0d want 1/2", state0, cin0);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++;
    if ({state0, interval0, done0, pulse0, wrap0} !== '0 ||
        {state1, interval1, done1, pulse1, wrap1} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid got st=%0d itv=%0d done=%0d wrap=%0d / ar st=%0d itv=%0d want all 0",
               state0, interval0, done0, wrap0, state1, interval1);
    end
    interval_in = 32'd6;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    tests_run++;
    if (state0 !== 8'd0) begin
      tests_failed++; $display("FAIL rst_restart_latency got %0d want 0", state0);
    end
    tick();
    tests_run++;
    if (state0 !== 8'd1 || interval0 !== 32'd6) begin
      tests_failed++; $display("FAIL rst_restart got st=%0d itv=%0d want 1/6", state0, interval0);
    end
  endtask

  task automatic test_random();
    int unsigned r;
    for (int i = 0; i < 500; i++) begin
      // at most one command level changes per cycle
      r = $urandom_range(0, 19);
      if (r < 3)       start = ~start;
      else if (r < 5)  stop  = ~stop;
      else if (r == 5) clear = ~clear;
      if ($urandom_range(0, 7) == 0) interval_in = $urandom_range(0, 12);
      tick();
      tests_run++;
      if ({state0, interval0, done0, pulse0, wrap0} !==
          {m0.st, m0.itv, m0.done, m0.pulse, 16'(m0.wrap)}) begin
        tests_failed++;
        $display("FAIL rand_dut cyc=%0d got st=%0d itv=%0d done=%0d pulse=%0d wrap=%0d want %0d/%0d/%0d/%0d/%0d",
                 i, state0, interval0, done0, pulse0, wrap0,
                 m0.st, m0.itv, m0.done, m0.pulse, m0.wrap);
      end
      tests_run++;
      if ({state1, interval1, done1, pulse1, wrap1} !==
          {m1.st, m1.itv, m1.done, m1.pulse, 2'(m1.wrap)}) begin
        tests_failed++;
        $display("FAIL rand_dut_ar cyc=%0d got st=%0d itv=%0d done=%0d pulse=%0d wrap=%0d want %0d/%0d/%0d/%0d/%0d",
                 i, state1, interval1, done1, pulse1, wrap1,
                 m1.st, m1.itv, m1.done, m1.pulse, m1.wrap);
      end
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    interval_in = '0;
    test_reset();
    test_basic();
    test_halt();
    test_coincident();
    test_zero_interval();
    test_auto_reload();
    test_rst_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Control stage directly upstream of the interval counter.
- Turns raw start/stop/clear command levels into the counter's 8-bit state code, latches the interval word, and monitors the returned counter value.
- Flags completion and optionally auto-reloads.
- Sits between the board button/switch inputs (or host register bank) and the counter instance.

Parameters:
- AUTO_RELOAD, 0: 1 = on completion, restart counting automatically; 0 = stop in DONE.
- WRAP_W, 16: width of the completed-interval tally.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command level; rising edge = start/resume.
- stop  input  1  command level; rising edge = pause.
- clear  input  1  command level; rising edge = abort and zero.
- interval_in  input  32  requested terminal count, sampled on accepted start.
- counter_in  input  32  current value returned by the counter.
- state  output  8  to counter: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT; registered.
- interval  output  32  latched terminal count, to counter; registered.
- done  output  1  level, high while in DONE.
- done_pulse  output  1  one-cycle strobe per completed interval.
- wrap_count  output  WRAP_W  number of completed intervals since clear/reset, saturating.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - FSM = IDLE, state=8'd0, interval=0, done=0, done_pulse=0, wrap_count=0.
  - Edge-detect history = 0.
  - Reset overrides everything, including mid-RUN.
- Command inputs pass through two registers (s1, s2); edge = s1 & ~s2. A level held high yields exactly one command.
- Priority when several edges coincide: clear > stop > start.
- Latency: a command level first sampled at edge N produces the state output change at edge N+2.
- FSM states and state output:
  - IDLE -> 8'd0
  - RUN -> 8'd1
  - HALT -> 8'd2
  - DONE -> 8'd2
  - RELOAD -> 8'd0, one cycle
- IDLE:
  - start edge with interval_in != 0: latch interval <= interval_in; go RUN.
  - start edge with interval_in == 0: ignored, stay IDLE.
  - stop and clear edges: no effect.
- RUN:
  - clear edge: go IDLE, wrap_count <= 0.
  - else stop edge: go HALT.
  - else counter_in >= interval: completion.
    - AUTO_RELOAD=0: go DONE.
    - AUTO_RELOAD=1: go RELOAD.
    - done_pulse=1 for exactly that transition cycle; wrap_count += 1, saturating at all-ones.
- HALT:
  - start edge: go RUN; interval is not re-latched.
  - clear edge: go IDLE, wrap_count <= 0.
  - stop edge: ignored.
  - counter_in is not compared while halted.
- DONE:
  - done=1.
  - start edge: re-latch interval_in (if != 0) and go RELOAD; if interval_in == 0, stay DONE.
  - clear edge: go IDLE, done=0, wrap_count <= 0.
- RELOAD:
  - One cycle only; drives 8'd0 so the counter zeroes.
  - Next cycle: go RUN, unconditionally. A clear edge during RELOAD goes IDLE instead.
- The completion compare uses the registered interval and is unsigned 32-bit >=. Because the counter saturates at interval, completion is detected exactly once per run.
- done deasserts on the same edge that leaves DONE.
- interval changes only in IDLE->RUN and DONE->RELOAD.
- Unknown FSM encoding: recover to IDLE with outputs as after reset.

Test Plan:
- Reset, then start pulse with interval_in=5 -> state=8'd1 two edges after start is sampled, interval=5. Model counter to 5 -> exactly one done_pulse, done=1, state=8'd2, wrap_count=1.
- Run with interval_in=100; stop at counter_in=40; hold 20 cycles; start again -> state sequence 1,2,1. No done during HALT. Completion at 100. interval unchanged if interval_in is altered to 7 while halted.
- start, stop and clear rising on the same cycle while in RUN -> IDLE, state=8'd0, wrap_count=0. Start held high for 50 cycles from IDLE -> only one accepted command.
- start with interval_in=0 in IDLE -> stays IDLE, state=8'd0. interval_in=3 then start -> RUN with interval=3.
- AUTO_RELOAD=1, interval_in=4, loopback counter model -> repeating RUN/RELOAD. One done_pulse per period; wrap_count increments 1,2,3…; done stays 0. With WRAP_W=2, saturates at 3.
- Assert rst mid-RUN with counter_in=2 -> next edge: state=0, interval=0, done=0, wrap_count=0. Subsequent start behaves as from power-up.
